// File: rtl/instrumented_adder_meas_pkg.sv
// Shared definitions for the instrumented-adder delay measurement block.
//   meas_state_e : measurement FSM states
//   MIN_LAT      : COUNT cycles seen for a zero-delay adder (2-flop sync + detect)
//   sat_add      : unsigned add that clamps at 2^w-1 (w <= 63)
package instrumented_adder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        LAUNCH,
        COUNT,
        DONE
    } meas_state_e;

    localparam int MIN_LAT = 3;

    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = (65'd1 << w) - 65'd1;
        if (sum > max) begin
            sum = max;
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/instrumented_adder_meas_sync.sv
// Two-flop synchroniser for one bit of the asynchronous adder sum.
//   clk_i  : sampling clock
//   rst_ni : asynchronous active-low reset, both flops clear to 0
//   d_i    : asynchronous input bit
//   q_o    : synchronised output
module adder_bit_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/instrumented_adder_meas.sv
// Delay-measurement controller for an external combinational adder.
// Drives operands, toggles one A bit, and counts cycles until the watched
// sum bit changes; repeats 'runs' times and accumulates a saturating total.
//   wb_clk_i, wb_rst_n     : clock, asynchronous active-low reset
//   start                  : 1-cycle request, accepted only in IDLE
//   a_base, b_base         : operands latched on accepted start
//   in_sel, out_sel        : toggled A bit / watched sum bit
//   runs                   : repetitions (0 treated as 1)
//   adder_a, adder_b       : registered operands to the adder
//   adder_s                : adder sum (asynchronous)
//   busy, done, timeout    : status (done is a 1-cycle pulse, timeout sticky)
//   count, last            : accumulated and most recent run counts
module instrumented_adder_meas
    import instrumented_adder_pkg::*;
#(
    parameter  int WIDTH      = 32,
    parameter  int COUNT_W    = 32,
    parameter  int SETTLE_CYC = 4,
    parameter  int TIMEOUT    = 1024,
    localparam int SEL_W      = $clog2(WIDTH)
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_base,
    input  logic [WIDTH-1:0]   b_base,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic [SEL_W-1:0]   out_sel,
    input  logic [7:0]         runs,
    output logic [WIDTH-1:0]   adder_a,
    output logic [WIDTH-1:0]   adder_b,
    input  logic [WIDTH-1:0]   adder_s,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [COUNT_W-1:0] count,
    output logic [COUNT_W-1:0] last
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    meas_state_e        state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [SEL_W-1:0]   in_sel_q, in_sel_d;
    logic [SEL_W-1:0]   out_sel_q, out_sel_d;
    logic [7:0]         runs_left_q, runs_left_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               ref_q, ref_d;
    logic [WIDTH-1:0]   adder_a_q, adder_a_d;
    logic [WIDTH-1:0]   adder_b_q, adder_b_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] last_q, last_d;
    logic               timeout_q, timeout_d;

    logic               s_q;
    logic [COUNT_W-1:0] cnt_inc;

    adder_bit_sync u_sync (
        .clk_i  (wb_clk_i),
        .rst_ni (wb_rst_n),
        .d_i    (adder_s[out_sel_q]),
        .q_o    (s_q)
    );

    // cnt_inc is the run count including the current COUNT cycle.
    assign cnt_inc = cnt_q + COUNT_W'(1);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        in_sel_d    = in_sel_q;
        out_sel_d   = out_sel_q;
        runs_left_d = runs_left_q;
        settle_d    = settle_q;
        cnt_d       = cnt_q;
        ref_d       = ref_q;
        adder_a_d   = adder_a_q;
        adder_b_d   = adder_b_q;
        count_d     = count_q;
        last_d      = last_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d         = a_base;
                    b_d         = b_base;
                    in_sel_d    = in_sel;
                    out_sel_d   = out_sel;
                    runs_left_d = (runs == 8'd0) ? 8'd1 : runs;
                    count_d     = '0;
                    last_d      = '0;
                    timeout_d   = 1'b0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                adder_a_d = a_q;
                adder_b_d = b_q;
                settle_d  = SET_W'(SETTLE_CYC);
                state_d   = SETTLE;
            end
            SETTLE: begin
                settle_d = settle_q - SET_W'(1);
                if (settle_q == SET_W'(1)) begin
                    ref_d   = s_q;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                adder_a_d = adder_a_q ^ (WIDTH'(1) << in_sel_q);
                cnt_d     = '0;
                state_d   = COUNT;
            end
            COUNT: begin
                cnt_d = cnt_inc;
                // Detection is tested first so it wins over a same-cycle timeout.
                if (s_q != ref_q) begin
                    last_d  = cnt_inc;
                    count_d = COUNT_W'(sat_add(64'(count_q), 64'(cnt_inc), COUNT_W));
                    if (runs_left_q > 8'd1) begin
                        runs_left_d = runs_left_q - 8'd1;
                        state_d     = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end else if (cnt_inc == COUNT_W'(TIMEOUT)) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            in_sel_q    <= '0;
            out_sel_q   <= '0;
            runs_left_q <= '0;
            settle_q    <= '0;
            cnt_q       <= '0;
            ref_q       <= 1'b0;
            adder_a_q   <= '0;
            adder_b_q   <= '0;
            count_q     <= '0;
            last_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            in_sel_q    <= in_sel_d;
            out_sel_q   <= out_sel_d;
            runs_left_q <= runs_left_d;
            settle_q    <= settle_d;
            cnt_q       <= cnt_d;
            ref_q       <= ref_d;
            adder_a_q   <= adder_a_d;
            adder_b_q   <= adder_b_d;
            count_q     <= count_d;
            last_q      <= last_d;
            timeout_q   <= timeout_d;
        end
    end

    assign adder_a = adder_a_q;
    assign adder_b = adder_b_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign timeout = timeout_q;
    assign count   = count_q;
    assign last    = last_q;

endmodule
